// File: rtl/shift_cmd_sequencer_pkg.sv
// Shared definitions for the shift command sequencer: opcodes, FSM states,
// command record layout and default widths.
package shift_cmd_sequencer_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SHW   = 4;

    // Shift register opcodes; codes 5..7 are illegal
    localparam logic [2:0] LOAD       = 3'd0;
    localparam logic [2:0] LOG_RIGHT  = 3'd1;
    localparam logic [2:0] LOG_LEFT   = 3'd2;
    localparam logic [2:0] ARIF_RIGHT = 3'd3;
    localparam logic [2:0] ARIF_LEFT  = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Command record as stored in the FIFO: {op, data, amt}
    typedef struct packed {
        logic [2:0]           op;
        logic [DEF_WIDTH-1:0] data;
        logic [DEF_SHW-1:0]   amt;
    } cmd_t;

    function automatic logic op_legal(input logic [2:0] op);
        return (op <= ARIF_LEFT);
    endfunction

endpackage

// File: rtl/shift_cmd_fifo.sv
// Synchronous command FIFO, show-ahead read port, full/empty flags.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module shift_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 23
) (
    input  logic         clk,
    input  logic         res,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    // Next pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
        else if (!do_push && do_pop) cnt_d = cnt_q - (AW+1)'(1);
    end

    // Control state, cleared asynchronously
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array, no reset needed since reads are gated by empty
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/shift_cmd_sequencer.sv
// Command sequencer in front of the 16-bit shift register: queues commands,
// drives reg_set/reg_d/reg_m, waits SETTLE_CYC edges, returns reg_q.
// Optional build macro SEQ_CHECK_EN adds a result model and sticky chk_err.
module shift_cmd_sequencer
    import shift_cmd_sequencer_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int SHW        = DEF_SHW,
    parameter int DEPTH      = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             res,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [SHW-1:0]   cmd_amt,
    output logic [2:0]       reg_set,
    output logic [WIDTH-1:0] reg_d,
    output logic [SHW-1:0]   reg_m,
    input  logic [WIDTH-1:0] reg_q,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [2:0]       rsp_op,
    output logic             rsp_err,
    output logic             busy,
    output logic             chk_err
);

    localparam int CMD_W = 3 + WIDTH + SHW;
    localparam int CNT_W = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

    logic [CMD_W-1:0] head;
    logic [2:0]       head_op;
    logic [WIDTH-1:0] head_data;
    logic [SHW-1:0]   head_amt;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic             capture;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       reg_set_q, reg_set_d;
    logic [WIDTH-1:0] reg_d_q, reg_d_d;
    logic [SHW-1:0]   reg_m_q, reg_m_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [2:0]       rsp_op_q, rsp_op_d;
    logic             rsp_err_q, rsp_err_d;

    shift_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .res     (res),
        .push    (cmd_valid),
        .wr_data ({cmd_op, cmd_data, cmd_amt}),
        .pop     (fifo_pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head_op   = head[CMD_W-1 -: 3];
    assign head_data = head[SHW +: WIDTH];
    assign head_amt  = head[SHW-1:0];

    assign cmd_ready = !fifo_full;
    assign capture   = (state_q == DRIVE) && (cnt_q == CNT_LAST);
    assign busy      = (state_q != IDLE) || !fifo_empty;
    assign rsp_valid = (state_q == RESP);
    assign reg_set   = reg_set_q;
    assign reg_d     = reg_d_q;
    assign reg_m     = reg_m_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_op    = rsp_op_q;
    assign rsp_err   = rsp_err_q;

    // Next-state and output logic; reg_* only change when a legal command is issued
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        reg_set_d  = reg_set_q;
        reg_d_d    = reg_d_q;
        reg_m_d    = reg_m_q;
        rsp_data_d = rsp_data_q;
        rsp_op_d   = rsp_op_q;
        rsp_err_d  = rsp_err_q;
        fifo_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (op_legal(head_op)) begin
                        reg_set_d = head_op;
                        reg_d_d   = head_data;
                        reg_m_d   = head_amt;
                        cnt_d     = '0;
                        state_d   = DRIVE;
                    end else begin
                        rsp_data_d = '0;
                        rsp_op_d   = head_op;
                        rsp_err_d  = 1'b1;
                        state_d    = RESP;
                    end
                end
            end
            DRIVE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (capture) begin
                    rsp_data_d = reg_q;
                    rsp_op_d   = reg_set_q;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            reg_set_q  <= '0;
            reg_d_q    <= '0;
            reg_m_q    <= '0;
            rsp_data_q <= '0;
            rsp_op_q   <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            reg_set_q  <= reg_set_d;
            reg_d_q    <= reg_d_d;
            reg_m_q    <= reg_m_d;
            rsp_data_q <= rsp_data_d;
            rsp_op_q   <= rsp_op_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

`ifdef SEQ_CHECK_EN
    logic chk_err_q, chk_err_d;

    function automatic logic [WIDTH-1:0] expect_result(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] d,
        input logic [SHW-1:0]   m
    );
        case (op)
            LOAD:                expect_result = d;
            LOG_RIGHT:           expect_result = d >> m;
            LOG_LEFT, ARIF_LEFT: expect_result = d << m;
            ARIF_RIGHT:          expect_result = $unsigned($signed(d) >>> m);
            default:             expect_result = d;
        endcase
    endfunction

    // Sticky mismatch flag, compared against the still-held command at capture
    always_comb begin
        chk_err_d = chk_err_q;
        if (capture && (expect_result(reg_set_q, reg_d_q, reg_m_q) != reg_q))
            chk_err_d = 1'b1;
    end

    // Mismatch flag register, cleared only by reset
    always_ff @(posedge clk or negedge res) begin
        if (!res) chk_err_q <= 1'b0;
        else      chk_err_q <= chk_err_d;
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Directed bench for shift_cmd_sequencer with a behavioural shift register
// attached to reg_set/reg_d/reg_m/reg_q.
module tb_shift_cmd_sequencer;

    logic        clk = 1'b0;
    logic        res;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_data;
    logic [3:0]  cmd_amt;
    logic [2:0]  reg_set;
    logic [15:0] reg_d;
    logic [3:0]  reg_m;
    logic [15:0] reg_q;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic [2:0]  rsp_op;
    logic        rsp_err, busy, chk_err;

    logic [15:0] reg_q_mdl = '0;
    logic        force_en  = 1'b0;
    logic [15:0] force_val = '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0]  t_op   [6];
    logic [15:0] t_data [6];
    logic [3:0]  t_amt  [6];
    logic [15:0] t_exp  [6];

    shift_cmd_sequencer dut (
        .clk       (clk),
        .res       (res),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_amt   (cmd_amt),
        .reg_set   (reg_set),
        .reg_d     (reg_d),
        .reg_m     (reg_m),
        .reg_q     (reg_q),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_op    (rsp_op),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .chk_err   (chk_err)
    );

    always #5 clk = ~clk;

    // Attached shift register: output follows its set/D/M inputs one edge later
    always @(posedge clk) begin
        case (reg_set)
            3'd0:       reg_q_mdl <= reg_d;
            3'd1:       reg_q_mdl <= reg_d >> reg_m;
            3'd2, 3'd4: reg_q_mdl <= reg_d << reg_m;
            3'd3:       reg_q_mdl <= $unsigned($signed(reg_d) >>> reg_m);
            default:    reg_q_mdl <= reg_q_mdl;
        endcase
    end
    assign reg_q = force_en ? force_val : reg_q_mdl;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    // Present one command from a negedge; returns on the negedge after acceptance
    task automatic send(input logic [2:0] op, input logic [15:0] data, input logic [3:0] amt);
        int t = 0;
        cmd_op    = op;
        cmd_data  = data;
        cmd_amt   = amt;
        cmd_valid = 1'b1;
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) chk("send_timeout", 32'd0, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Wait for a response, check it, then complete the handshake
    task automatic get_rsp(input string tag, input logic [15:0] data,
                           input logic [2:0] op, input logic err);
        int t = 0;
        while (!rsp_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!rsp_valid) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_data"}, 32'(rsp_data), 32'(data));
            chk({tag, "_op"},   32'(rsp_op),   32'(op));
            chk({tag, "_err"},  32'(rsp_err),  32'(err));
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, k, t;
        logic r, acc;

        t_op[0] = 3'd0; t_data[0] = 16'h0001; t_amt[0] = 4'd0; t_exp[0] = 16'h0001;
        t_op[1] = 3'd2; t_data[1] = 16'h0003; t_amt[1] = 4'd2; t_exp[1] = 16'h000C;
        t_op[2] = 3'd1; t_data[2] = 16'hF000; t_amt[2] = 4'd4; t_exp[2] = 16'h0F00;
        t_op[3] = 3'd3; t_data[3] = 16'h8000; t_amt[3] = 4'd3; t_exp[3] = 16'hF000;
        t_op[4] = 3'd4; t_data[4] = 16'h0101; t_amt[4] = 4'd1; t_exp[4] = 16'h0202;
        t_op[5] = 3'd0; t_data[5] = 16'hBEEF; t_amt[5] = 4'd0; t_exp[5] = 16'hBEEF;

        res = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_amt = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_reg_set",   32'(reg_set),   32'd0);
        chk("rst_reg_d",     32'(reg_d),     32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_chk_err",   32'(chk_err),   32'd0);
        res = 1'b1;
        @(negedge clk);

        // Single command latency: 0x8000 >> 4
        send(3'd1, 16'h8000, 4'd4);
        chk("lat_e0_valid", 32'(rsp_valid), 32'd0);
        chk("lat_e0_busy",  32'(busy),      32'd1);
        @(negedge clk);
        chk("lat_reg_set", 32'(reg_set), 32'd1);
        chk("lat_reg_d",   32'(reg_d),   32'h8000);
        chk("lat_reg_m",   32'(reg_m),   32'd4);
        chk("lat_e1_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("lat_e2_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("lat_e3_valid", 32'(rsp_valid), 32'd1);
        get_rsp("lat", 16'h0800, 3'd1, 1'b0);
        chk("lat_after_hs_valid", 32'(rsp_valid), 32'd0);

        // Two queued commands, in-order results
        send(3'd2, 16'h00FF, 4'd8);
        send(3'd0, 16'h1234, 4'd0);
        get_rsp("pair0", 16'hFF00, 3'd2, 1'b0);
        get_rsp("pair1", 16'h1234, 3'd0, 1'b0);

        // Back-to-back burst with the consumer stalled: DEPTH+1 accepted
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            cmd_op    = t_op[idx];
            cmd_data  = t_data[idx];
            cmd_amt   = t_amt[idx];
            cmd_valid = 1'b1;
            r = cmd_ready;
            @(negedge clk);
            if (r) idx++;
        end
        chk("burst_accepted",  32'(idx),       32'd5);
        chk("burst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("burst_rsp_valid", 32'(rsp_valid), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_rsp_data",  32'(rsp_data),  32'h0001);
            chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        k = 0;
        t = 0;
        while (k < 6 && t < 300) begin
            if (rsp_valid) begin
                chk("drain_data", 32'(rsp_data), 32'(t_exp[k]));
                chk("drain_op",   32'(rsp_op),   32'(t_op[k]));
                k++;
            end
            acc = cmd_valid && cmd_ready;
            @(negedge clk);
            t++;
            if (acc) begin
                idx++;
                cmd_valid = 1'b0;
            end
        end
        rsp_ready = 1'b0;
        chk("drain_count",    32'(k),   32'd6);
        chk("drain_accepted", 32'(idx), 32'd6);
        chk("drain_idle",     32'(busy), 32'd0);

        // Full-range left shift, then an illegal opcode
        send(3'd4, 16'h0001, 4'd15);
        get_rsp("asl15", 16'h8000, 3'd4, 1'b0);
        send(3'd6, 16'hAAAA, 4'd3);
        chk("ill_e0_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("ill_valid",   32'(rsp_valid), 32'd1);
        chk("ill_reg_set", 32'(reg_set),   32'd4);
        chk("ill_reg_d",   32'(reg_d),     32'h0001);
        chk("ill_reg_m",   32'(reg_m),     32'd15);
        get_rsp("ill", 16'h0000, 3'd6, 1'b1);

        // Reset while in DRIVE with one more command queued
        send(3'd1, 16'h1234, 4'd1);
        send(3'd2, 16'h0F0F, 4'd4);
        chk("mid_busy", 32'(busy), 32'd1);
        #2 res = 1'b0;
        #1;
        chk("mid_rst_reg_set",   32'(reg_set),   32'd0);
        chk("mid_rst_reg_d",     32'(reg_d),     32'd0);
        chk("mid_rst_reg_m",     32'(reg_m),     32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy",      32'(busy),      32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        res = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("dropped_no_rsp", 32'(rsp_valid), 32'd0);
        end
        send(3'd1, 16'h0010, 4'd1);
        get_rsp("post_rst", 16'h0008, 3'd1, 1'b0);

`ifdef SEQ_CHECK_EN
        send(3'd3, 16'h4000, 4'd2);
        get_rsp("chk_asr", 16'h1000, 3'd3, 1'b0);
        chk("chk_clean", 32'(chk_err), 32'd0);
        force_val = 16'hFFFF;
        force_en  = 1'b1;
        send(3'd0, 16'h5555, 4'd0);
        get_rsp("chk_forced", 16'hFFFF, 3'd0, 1'b0);
        force_en = 1'b0;
        chk("chk_set", 32'(chk_err), 32'd1);
        send(3'd0, 16'h00AA, 4'd0);
        get_rsp("chk_after", 16'h00AA, 3'd0, 1'b0);
        chk("chk_sticky", 32'(chk_err), 32'd1);
        res = 1'b0;
        #1;
        chk("chk_rst", 32'(chk_err), 32'd0);
        @(negedge clk);
        res = 1'b1;
`else
        chk("chk_tied_low", 32'(chk_err), 32'd0);
`endif

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_cmd_sequencer.md
Name: shift_cmd_sequencer

Overview:
- Upstream command stage for the 16-bit shift register (load, logical shift left/right, arithmetic shift left/right).
- Queues shift commands from a valid/ready source and drives the register's set/D/M inputs one command at a time.
- Waits for the register's state machine to settle, captures its output, and returns the result on a valid/ready response port.

Parameters:
- WIDTH, 16, data width of the operand and result.
- SHW, 4, shift-amount width.
- DEPTH, 4, command FIFO depth (power of two).
- SETTLE_CYC, 2, clock edges between driving reg_* and capturing reg_q (minimum 2).

Ports:
- clk  in  1  clock, rising edge.
- res  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept.
- cmd_op  in  3  0=LOAD 1=LOG_RIGHT 2=LOG_LEFT 3=ARIF_RIGHT 4=ARIF_LEFT.
- cmd_data  in  WIDTH  operand.
- cmd_amt  in  SHW  shift amount.
- reg_set  out  3  to the register's set input.
- reg_d  out  WIDTH  to the register's D input.
- reg_m  out  SHW  to the register's M input.
- reg_q  in  WIDTH  from the register's outstate.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts.
- rsp_data  out  WIDTH  captured result.
- rsp_op  out  3  opcode of the result.
- rsp_err  out  1  opcode was illegal (5-7).
- busy  out  1  FSM not IDLE or FIFO non-empty.
- chk_err  out  1  sticky self-check mismatch flag (see Optional Feature).

Behaviour:
- Reset (res=0, asynchronous): FIFO emptied, FSM=IDLE, reg_set=0, reg_d=0, reg_m=0, rsp_valid=0, rsp_data=0, rsp_op=0, rsp_err=0, chk_err=0.
  - Reset mid-command discards the in-flight command and all queued commands without a response.
- FIFO: push when cmd_valid & cmd_ready; cmd_ready = !full.
  - Push and pop in the same cycle are both honoured.
  - Pointers wrap modulo DEPTH.
  - A push when full is ignored (the source must hold its command).
- All reg_* outputs are registered. They hold their last value in every state except DRIVE entry, so the register's state and output stay stable between commands.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head.
    - Legal op: load reg_set/reg_d/reg_m from the head, clear settle counter, go to DRIVE.
    - Illegal op: leave reg_* unchanged, load rsp_data=0, rsp_op=op, rsp_err=1, go to RESP.
  - DRIVE: counter increments each edge. At the edge where counter = SETTLE_CYC-1: rsp_data<=reg_q, rsp_op<=reg_set, rsp_err<=0, go to RESP.
  - RESP: rsp_valid=1. On rsp_valid & rsp_ready go to IDLE. rsp_* hold stable while rsp_ready=0.
- Latency: a command accepted at edge e0 into an empty FIFO with the FSM idle is popped at e0+1. rsp_valid rises after edge e0+1+SETTLE_CYC (3 cycles by default). An illegal op responds after e0+1.
- Throughput: one command per (SETTLE_CYC+2) cycles with rsp_ready held high.
- The DEPTH+1 command limit is DEPTH queued plus one in flight. cmd_ready stays high while FIFO occupancy < DEPTH.

Optional Feature:
- Macro: SEQ_CHECK_EN.
- Defined: at capture, an internal model computes the expected result from the popped command:
  - LOAD -> data.
  - LOG_RIGHT -> logical right shift, zero fill.
  - LOG_LEFT -> left shift.
  - ARIF_RIGHT -> sign-filling right shift.
  - ARIF_LEFT -> same as left shift.
  - If the expected value differs from reg_q, chk_err is set and stays set until reset.
- Not defined: model omitted; chk_err is tied to 0.

Decomposition:
- Shared package holds:
  - opcode constants LOAD, LOG_RIGHT, LOG_LEFT, ARIF_RIGHT, ARIF_LEFT;
  - FSM state encoding IDLE/DRIVE/RESP;
  - command record layout {op, data, amt};
  - the default WIDTH and SHW values.
- One sub-module: shift_cmd_fifo (synchronous FIFO, DEPTH x (3+WIDTH+SHW), full/empty flags, same clk/res).

Test Plan:
- Reset, then cmd op=1 data=0x8000 amt=4 with the shift register attached -> reg_set=1, reg_d=0x8000, reg_m=4; rsp_valid 3 cycles after accept; rsp_data=0x0800, rsp_op=1, rsp_err=0.
- op=2 data=0x00FF amt=8, then op=0 data=0x1234 -> responses in order: 0xFF00, then 0x1234.
- rsp_ready=0, push 6 commands back-to-back -> 5 accepted; cmd_ready low after 5th until rsp_ready=1; all responses delivered in order; rsp_data stable while stalled.
- op=6 data=0xAAAA -> rsp_valid after 1 cycle, rsp_err=1, rsp_data=0, reg_set unchanged.
- Assert res=0 while in DRIVE -> all outputs at reset values immediately; no response for the dropped command; next command op=1 data=0x0010 amt=1 -> 0x0008.
- With SEQ_CHECK_EN: op=3 data=0x4000 amt=2 -> rsp_data=0x1000, chk_err=0. Force reg_q=0xFFFF during capture -> chk_err=1 and stays 1 until reset.
